rscpu_control_unit: RTL

//   Hardwired control unit for the Relatively Simple CPU. It sequences fetch/decode/execute
//   for the 16-instruction ISA and drives all register load/inc strobes, bus-driver enables,

---
 rtl/rscpu_ctrl_pkg.sv | 95 +++++++++
 rtl/rscpu_ctrl_decode.sv | 94 +++++++++
 rtl/rscpu_control_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/rscpu_ctrl_pkg.sv
// Shared definitions for the Relatively Simple CPU control unit: opcodes, ALUSEL codes,
// state encodings and the strobe/bus bit positions used by the datapath top.
package rscpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDAC = 4'h1;
    localparam logic [3:0] OP_STAC = 4'h2;
    localparam logic [3:0] OP_MVAC = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_JUMP = 4'h5;
    localparam logic [3:0] OP_JMPZ = 4'h6;
    localparam logic [3:0] OP_JPNZ = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_INAC = 4'hA;
    localparam logic [3:0] OP_CLAC = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

    localparam logic [6:0] ALU_NONE = 7'b0000000;
    localparam logic [6:0] ALU_ADD  = 7'b0000101;
    localparam logic [6:0] ALU_SUB  = 7'b0001011;
    localparam logic [6:0] ALU_INAC = 7'b0001001;
    localparam logic [6:0] ALU_CLAC = 7'b0000000;
    localparam logic [6:0] ALU_PASS = 7'b0000100;
    localparam logic [6:0] ALU_AND  = 7'b1000000;
    localparam logic [6:0] ALU_OR   = 7'b1100000;
    localparam logic [6:0] ALU_XOR  = 7'b1010000;
    localparam logic [6:0] ALU_NOT  = 7'b1110000;

    localparam int LD_AR = 6;
    localparam int LD_PC = 5;
    localparam int LD_DR = 4;
    localparam int LD_TR = 3;
    localparam int LD_IR = 2;
    localparam int LD_R  = 1;
    localparam int LD_AC = 0;

    localparam int INC_AR = 1;
    localparam int INC_PC = 0;

    localparam int RW_READ  = 1;
    localparam int RW_WRITE = 0;

    localparam int BUS_MEM = 5;
    localparam int BUS_PC  = 4;
    localparam int BUS_DR  = 3;
    localparam int BUS_TR  = 2;
    localparam int BUS_R   = 1;
    localparam int BUS_AC  = 0;

    typedef enum logic [5:0] {
        StFetch1, StFetch2, StFetch3, StNop1,
        StLdac1, StLdac2, StLdac3, StLdac4, StLdac5,
        StStac1, StStac2, StStac3, StStac4, StStac5,
        StMvac1, StMovr1,
        StJump1, StJump2, StJump3,
        StJmpzY1, StJmpzY2, StJmpzY3, StJmpzN1, StJmpzN2,
        StJpnzY1, StJpnzY2, StJpnzY3, StJpnzN1, StJpnzN2,
        StAdd1, StSub1, StInac1, StClac1, StAnd1, StOr1, StXor1, StNot1
    } state_e;

    // States that hold a memory access until mem_ready
    function automatic logic is_mem_state(state_e s);
        case (s)
            StFetch2, StLdac1, StLdac2, StLdac4, StStac1, StStac2, StStac5,
            StJump1, StJump2, StJmpzY1, StJmpzY2, StJpnzY1, StJpnzY2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic state_e opcode_entry(logic [3:0] op, logic z);
        case (op)
            OP_NOP:  return StNop1;
            OP_LDAC: return StLdac1;
            OP_STAC: return StStac1;
            OP_MVAC: return StMvac1;
            OP_MOVR: return StMovr1;
            OP_JUMP: return StJump1;
            OP_JMPZ: return z ? StJmpzY1 : StJmpzN1;
            OP_JPNZ: return z ? StJpnzN1 : StJpnzY1;
            OP_ADD:  return StAdd1;
            OP_SUB:  return StSub1;
            OP_INAC: return StInac1;
            OP_CLAC: return StClac1;
            OP_AND:  return StAnd1;
            OP_OR:   return StOr1;
            OP_XOR:  return StXor1;
            default: return StNot1;
        endcase
    endfunction

endpackage

// File: rtl/rscpu_ctrl_decode.sv
// Combinational decode of control state into register strobes, bus enables and ALUSEL.
// Load/increment strobes of memory states are withheld until the memory is ready.
module rscpu_ctrl_decode
    import rscpu_ctrl_pkg::*;
(
    input  state_e      i_state,
    input  logic        i_ready,
    output logic [6:0]  o_alusel,
    output logic [6:0]  o_ld,
    output logic [1:0]  o_inc,
    output logic        o_zload,
    output logic [1:0]  o_mem_rw,
    output logic [5:0]  o_bus_drv
);

    logic [6:0] w_ld_raw;
    logic [1:0] w_inc_raw;
    logic       w_hold;

    always_comb begin
        w_ld_raw  = '0;
        w_inc_raw = '0;
        o_alusel  = ALU_NONE;
        o_zload   = 1'b0;
        o_mem_rw  = '0;
        o_bus_drv = '0;
        unique case (i_state)
            StFetch1: begin w_ld_raw[LD_AR] = 1'b1; o_bus_drv[BUS_PC] = 1'b1; end
            StFetch2: begin
                o_mem_rw[RW_READ] = 1'b1; o_bus_drv[BUS_MEM] = 1'b1;
                w_ld_raw[LD_DR] = 1'b1; w_inc_raw[INC_PC] = 1'b1;
            end
            StFetch3: begin
                w_ld_raw[LD_IR] = 1'b1; w_ld_raw[LD_AR] = 1'b1; o_bus_drv[BUS_PC] = 1'b1;
            end
            StNop1: ;
            StLdac1, StStac1: begin
                o_mem_rw[RW_READ] = 1'b1; o_bus_drv[BUS_MEM] = 1'b1; w_ld_raw[LD_DR] = 1'b1;
                w_inc_raw[INC_PC] = 1'b1; w_inc_raw[INC_AR] = 1'b1;
            end
            StLdac2, StStac2: begin
                o_mem_rw[RW_READ] = 1'b1; o_bus_drv[BUS_MEM] = 1'b1; w_ld_raw[LD_TR] = 1'b1;
                w_ld_raw[LD_DR] = 1'b1; w_inc_raw[INC_PC] = 1'b1;
            end
            StLdac3, StStac3: begin
                w_ld_raw[LD_AR] = 1'b1; o_bus_drv[BUS_DR] = 1'b1; o_bus_drv[BUS_TR] = 1'b1;
            end
            StLdac4: begin
                o_mem_rw[RW_READ] = 1'b1; o_bus_drv[BUS_MEM] = 1'b1; w_ld_raw[LD_DR] = 1'b1;
            end
            StLdac5: begin
                w_ld_raw[LD_AC] = 1'b1; o_bus_drv[BUS_DR] = 1'b1; o_alusel = ALU_PASS;
            end
            StStac4: begin w_ld_raw[LD_DR] = 1'b1; o_bus_drv[BUS_AC] = 1'b1; end
            // DR drives the bus; write steers it into memory
            StStac5: begin o_mem_rw[RW_WRITE] = 1'b1; o_bus_drv[BUS_DR] = 1'b1; end
            StMvac1: begin w_ld_raw[LD_R] = 1'b1; o_bus_drv[BUS_AC] = 1'b1; end
            StMovr1: begin
                w_ld_raw[LD_AC] = 1'b1; o_bus_drv[BUS_R] = 1'b1; o_alusel = ALU_PASS;
            end
            StJump1, StJmpzY1, StJpnzY1: begin
                o_mem_rw[RW_READ] = 1'b1; o_bus_drv[BUS_MEM] = 1'b1; w_ld_raw[LD_DR] = 1'b1;
                w_inc_raw[INC_AR] = 1'b1;
            end
            StJump2, StJmpzY2, StJpnzY2: begin
                o_mem_rw[RW_READ] = 1'b1; o_bus_drv[BUS_MEM] = 1'b1; w_ld_raw[LD_TR] = 1'b1;
                w_ld_raw[LD_DR] = 1'b1;
            end
            StJump3, StJmpzY3, StJpnzY3: begin
                w_ld_raw[LD_PC] = 1'b1; o_bus_drv[BUS_DR] = 1'b1; o_bus_drv[BUS_TR] = 1'b1;
            end
            StJmpzN1, StJmpzN2, StJpnzN1, StJpnzN2: w_inc_raw[INC_PC] = 1'b1;
            StAdd1, StSub1, StAnd1, StOr1, StXor1: begin
                w_ld_raw[LD_AC] = 1'b1; o_zload = 1'b1; o_bus_drv[BUS_R] = 1'b1;
                unique case (i_state)
                    StAdd1:  o_alusel = ALU_ADD;
                    StSub1:  o_alusel = ALU_SUB;
                    StAnd1:  o_alusel = ALU_AND;
                    StOr1:   o_alusel = ALU_OR;
                    default: o_alusel = ALU_XOR;
                endcase
            end
            StInac1: begin w_ld_raw[LD_AC] = 1'b1; o_zload = 1'b1; o_alusel = ALU_INAC; end
            StClac1: begin w_ld_raw[LD_AC] = 1'b1; o_zload = 1'b1; o_alusel = ALU_CLAC; end
            StNot1:  begin w_ld_raw[LD_AC] = 1'b1; o_zload = 1'b1; o_alusel = ALU_NOT; end
            default: ;
        endcase
    end

    assign w_hold = is_mem_state(i_state) && !i_ready;
    assign o_ld   = w_hold ? '0 : w_ld_raw;
    assign o_inc  = w_hold ? '0 : w_inc_raw;

endmodule

// File: rtl/rscpu_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the Relatively Simple CPU.
// Holds the state register and next-state logic; strobes come from rscpu_ctrl_decode.
module rscpu_control_unit
    import rscpu_ctrl_pkg::*;
#(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned STATE_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         dr_in,
    input  logic               z_flag,
    input  logic               mem_ready,
    output logic [6:0]         alusel,
    output logic [6:0]         ld,
    output logic [1:0]         inc,
    output logic               zload,
    output logic [1:0]         mem_rw,
    output logic [5:0]         bus_drv,
    output logic [STATE_W-1:0] state_dbg
);

    state_e     r_state;
    state_e     w_state_seq;
    state_e     w_state_next;
    logic       w_ready;
    logic [6:0] w_alusel;
    logic [6:0] w_ld;
    logic [1:0] w_inc;
    logic       w_zload;
    logic [1:0] w_mem_rw;
    logic [5:0] w_bus_drv;

    assign w_ready = USE_MEM_READY ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StFetch1;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Final state of every instruction falls through to the StFetch1 default
    always_comb begin
        w_state_seq = StFetch1;
        unique case (r_state)
            StFetch1: w_state_seq = StFetch2;
            StFetch2: w_state_seq = StFetch3;
            StFetch3: w_state_seq = (dr_in[7:4] != 4'h0) ? StNop1
                                                         : opcode_entry(dr_in[3:0], z_flag);
            StLdac1:  w_state_seq = StLdac2;
            StLdac2:  w_state_seq = StLdac3;
            StLdac3:  w_state_seq = StLdac4;
            StLdac4:  w_state_seq = StLdac5;
            StStac1:  w_state_seq = StStac2;
            StStac2:  w_state_seq = StStac3;
            StStac3:  w_state_seq = StStac4;
            StStac4:  w_state_seq = StStac5;
            StJump1:  w_state_seq = StJump2;
            StJump2:  w_state_seq = StJump3;
            StJmpzY1: w_state_seq = StJmpzY2;
            StJmpzY2: w_state_seq = StJmpzY3;
            StJmpzN1: w_state_seq = StJmpzN2;
            StJpnzY1: w_state_seq = StJpnzY2;
            StJpnzY2: w_state_seq = StJpnzY3;
            StJpnzN1: w_state_seq = StJpnzN2;
            default:  w_state_seq = StFetch1;
        endcase
        w_state_next = (is_mem_state(r_state) && !w_ready) ? r_state : w_state_seq;
    end

    rscpu_ctrl_decode u_decode (
        .i_state   (r_state),
        .i_ready   (w_ready),
        .o_alusel  (w_alusel),
        .o_ld      (w_ld),
        .o_inc     (w_inc),
        .o_zload   (w_zload),
        .o_mem_rw  (w_mem_rw),
        .o_bus_drv (w_bus_drv)
    );

    always_comb begin
        alusel  = w_alusel;
        ld      = w_ld;
        inc     = w_inc;
        zload   = w_zload;
        mem_rw  = w_mem_rw;
        bus_drv = w_bus_drv;
        if (rst) begin
            alusel  = '0;
            ld      = '0;
            inc     = '0;
            zload   = 1'b0;
            mem_rw  = '0;
            bus_drv = '0;
        end
    end

    assign state_dbg = STATE_W'(r_state);

endmodule
